rsa_modexp: RTL

RSA_MODEXP -- requirements
Module: rsa_modexp

---
 rtl/rsa_modexp_pkg.sv | 22 ++
 rtl/mont_mul_core.sv | 85 ++++++++
 rtl/rsa_modexp.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_pkg.sv
// Shared width constant and FSM encodings for the RSA modular exponentiator.
// Imported by rsa_modexp and mont_mul_core.
package rsa_modexp_pkg;

    // Default operand width in bits.
    localparam int unsigned MODEXP_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        MONT,
        CALC,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_BUSY,
        MM_FIN
    } mm_state_e;

endpackage

// File: rtl/mont_mul_core.sv
// Bit-serial radix-2 Montgomery multiplier: p = x*z*2^-W mod n, fully reduced.
// Start pulse in; W iteration cycles; one-cycle finished pulse with p valid.
module mont_mul_core import rsa_modexp_pkg::*; #(
    parameter int unsigned W = MODEXP_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_z,
    input  logic [W-1:0] i_n,
    output logic [W-1:0] o_p,
    output logic         o_finished
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    mm_state_e     state_q, state_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  z_q, z_d;
    logic [W-1:0]  n_q, n_d;
    // Two guard bits: the accumulator stays below 2n, a partial sum below 4n.
    logic [W+1:0]  s_q, s_d;
    logic [W+1:0]  sum_xz, sum_n;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= MM_IDLE;
            x_q     <= '0;
            z_q     <= '0;
            n_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            z_q     <= z_d;
            n_q     <= n_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        z_d        = z_q;
        n_d        = n_q;
        s_d        = s_q;
        cnt_d      = cnt_q;
        o_finished = 1'b0;
        sum_xz     = s_q + (x_q[0] ? {2'b00, z_q} : '0);
        sum_n      = sum_xz + (sum_xz[0] ? {2'b00, n_q} : '0);
        o_p        = (s_q >= {2'b00, n_q}) ? (s_q[W-1:0] - n_q) : s_q[W-1:0];

        unique case (state_q)
            MM_IDLE: begin
                if (i_start) begin
                    x_d     = i_x;
                    z_d     = i_z;
                    n_d     = i_n;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = MM_BUSY;
                end
            end
            MM_BUSY: begin
                // sum_n is even by construction, so the shift is exact.
                s_d   = sum_n >> 1;
                x_d   = x_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = MM_FIN;
                end
            end
            MM_FIN: begin
                o_finished = 1'b1;
                state_d    = MM_IDLE;
            end
            default: state_d = MM_IDLE;
        endcase
    end

endmodule

// File: rtl/rsa_modexp.sv
// Modular exponentiation y^e mod n: modular-doubling prep into the Montgomery
// domain, then an LSB-first exponent loop driving two Montgomery multipliers.
module rsa_modexp import rsa_modexp_pkg::*; #(
    parameter int unsigned W = MODEXP_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_e,
    input  logic [W-1:0] i_n,
    output logic [W-1:0] o_a_pow_e,
    output logic         o_finished
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    state_e        state_q, state_d;
    logic [W-1:0]  e_q, e_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  t_q, t_d;
    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  pm_q, pm_d;
    logic [W-1:0]  pt_q, pt_d;
    logic [W-1:0]  result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          pm_vld_q, pm_vld_d;
    logic          pt_vld_q, pt_vld_d;
    logic          issued_q, issued_d;
    logic          mul_start;
    logic [W:0]    dbl;
    logic [W-1:0]  p_m, p_t;
    logic          fin_m, fin_t;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            e_q      <= '0;
            n_q      <= '0;
            t_q      <= '0;
            m_q      <= '0;
            pm_q     <= '0;
            pt_q     <= '0;
            result_q <= '0;
            idx_q    <= '0;
            pm_vld_q <= 1'b0;
            pt_vld_q <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            n_q      <= n_d;
            t_q      <= t_d;
            m_q      <= m_d;
            pm_q     <= pm_d;
            pt_q     <= pt_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            pm_vld_q <= pm_vld_d;
            pt_vld_q <= pt_vld_d;
            issued_q <= issued_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        e_d        = e_q;
        n_d        = n_q;
        t_d        = t_q;
        m_d        = m_q;
        pm_d       = pm_q;
        pt_d       = pt_q;
        result_d   = result_q;
        idx_d      = idx_q;
        pm_vld_d   = pm_vld_q;
        pt_vld_d   = pt_vld_q;
        issued_d   = issued_q;
        mul_start  = 1'b0;
        o_finished = 1'b0;
        dbl        = {t_q, 1'b0};

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    e_d      = i_e;
                    n_d      = i_n;
                    t_d      = i_a;
                    m_d      = {{(W-1){1'b0}}, 1'b1};
                    result_d = '0;
                    idx_d    = '0;
                    state_d  = PREP;
                end
            end
            PREP: begin
                // t < n, so 2t < 2n: one conditional subtract fully reduces.
                t_d   = (dbl >= {1'b0, n_q}) ? (dbl[W-1:0] - n_q) : dbl[W-1:0];
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(W - 1)) begin
                    idx_d   = '0;
                    state_d = MONT;
                end
            end
            MONT: begin
                if (!issued_q) begin
                    mul_start = 1'b1;
                    issued_d  = 1'b1;
                end
                if (fin_m) begin
                    pm_d     = p_m;
                    pm_vld_d = 1'b1;
                end
                if (fin_t) begin
                    pt_d     = p_t;
                    pt_vld_d = 1'b1;
                end
                if ((pm_vld_q || fin_m) && (pt_vld_q || fin_t)) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                // The m-path product is always computed; it is only kept for set bits.
                if (e_q[idx_q]) begin
                    m_d = pm_q;
                end
                t_d      = pt_q;
                issued_d = 1'b0;
                pm_vld_d = 1'b0;
                pt_vld_d = 1'b0;
                if (idx_q == IW'(W - 1)) begin
                    result_d = e_q[idx_q] ? pm_q : m_q;
                    state_d  = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = MONT;
                end
            end
            DONE: begin
                o_finished = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_a_pow_e = result_q;

    mont_mul_core #(
        .W(W)
    ) u_mul_m (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (mul_start),
        .i_x        (m_q),
        .i_z        (t_q),
        .i_n        (n_q),
        .o_p        (p_m),
        .o_finished (fin_m)
    );

    mont_mul_core #(
        .W(W)
    ) u_mul_t (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (mul_start),
        .i_x        (t_q),
        .i_z        (t_q),
        .i_n        (n_q),
        .o_p        (p_t),
        .o_finished (fin_t)
    );

endmodule
